bus_write_logger: RTL and testbench

Passive store-capture stage sitting directly downstream of `cpu6502` on the CPU bus. It watches `addr`/`odata`/`rw` and `clk2`, and records every CPU write (`rw==0`) that falls in a configurable address window into a FIFO, tagged with a cycle timestamp. Benches and the on-board debug port drain that FIFO over a valid/ready handshake. It never drives the CPU bus.

---
 rtl/bus_write_logger_pkg.sv | 31 +++
 rtl/bus_write_logger_if.sv | 29 ++
 rtl/bus_write_logger_sync_fifo.sv | 64 ++++++
 rtl/bus_write_logger.sv | 114 +++++++++++
 tb/tb_bus_write_logger.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_write_logger_pkg.sv
// rtl/bus_write_logger_pkg.sv - shared field widths, entry layout and helpers for the bus write logger
package bus_write_logger_pkg;

    localparam int STAMP_W = 16;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = STAMP_W + ADDR_W + DATA_W;

    // Packed entry layout, most significant field first: {stamp, addr, data}
    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
    } log_entry_t;

    // Index width for a power-of-two FIFO depth (never below 1 bit)
    function automatic int idx_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Occupancy width: one more than the index so a full FIFO is representable
    function automatic int cnt_w(input int depth);
        return idx_w(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_write_logger_if.sv
// rtl/bus_write_logger_if.sv - log drain stream between the logger and its consumer
interface bus_write_logger_if;
    import bus_write_logger_pkg::*;

    logic               log_valid;
    logic               log_ready;
    logic [ADDR_W-1:0]  log_addr;
    logic [DATA_W-1:0]  log_data;
    logic [STAMP_W-1:0] log_stamp;

    // Logger side presents the head entry
    modport master (
        output log_valid,
        output log_addr,
        output log_data,
        output log_stamp,
        input  log_ready
    );

    // Consumer side accepts entries
    modport slave (
        input  log_valid,
        input  log_addr,
        input  log_data,
        input  log_stamp,
        output log_ready
    );

endinterface

// File: rtl/bus_write_logger_sync_fifo.sv
// rtl/bus_write_logger_sync_fifo.sv - circular-buffer FIFO with push/pop/clear and occupancy
module sync_fifo
    import bus_write_logger_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [idx_w(DEPTH):0]    o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = idx_w(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_count = r_wr - r_rd;
    assign o_rdata = r_mem[r_rd[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO is fine then
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

    // Pointer update; clear wins over push and pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_clear) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because empty masks the head downstream
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/bus_write_logger.sv
// rtl/bus_write_logger.sv - passive CPU store capture into a timestamped drainable FIFO
module bus_write_logger
    import bus_write_logger_pkg::*;
#(
    parameter int                DEPTH   = 8,
    parameter logic [ADDR_W-1:0] ADDR_LO = 16'h0000,
    parameter logic [ADDR_W-1:0] ADDR_HI = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clk2,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      odata,
    input  logic                   rw,
    input  logic                   clear,
    bus_write_logger_if.master     log_if,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                   overflow,
    output logic [7:0]             drops
);

    logic                r_clk2_q;
    logic [STAMP_W-1:0]  r_stamp;
    logic                r_overflow;
    logic [7:0]          r_drops;

    logic                w_rise;
    logic [ADDR_W:0]     w_lo_diff;
    logic [ADDR_W:0]     w_hi_diff;
    logic                w_in_win;
    logic                w_capture;
    logic                w_pop;
    logic                w_drop;
    logic                w_full;
    logic                w_empty;
    log_entry_t          w_wentry;
    logic [ENTRY_W-1:0]  w_rdata;
    log_entry_t          w_head;

    // Window test via borrow bits keeps the compare free of constant-folded relations
    assign w_lo_diff = {1'b0, addr} - {1'b0, ADDR_LO};
    assign w_hi_diff = {1'b0, ADDR_HI} - {1'b0, addr};
    assign w_in_win  = ~w_lo_diff[ADDR_W] & ~w_hi_diff[ADDR_W];

    // Store point is the start of phi2
    assign w_rise    = clk2 & ~r_clk2_q;
    assign w_capture = w_rise & ~rw & w_in_win;

    assign w_pop  = ~w_empty & log_if.log_ready & ~clear;
    assign w_drop = w_capture & ~clear & w_full & ~w_pop;

    assign w_wentry = '{stamp: r_stamp, addr: addr, data: odata};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_capture),
        .i_pop   (w_pop),
        .i_clear (clear),
        .i_wdata (w_wentry),
        .o_rdata (w_rdata),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head fields read as zero whenever nothing is queued
    assign w_head           = w_empty ? '0 : log_entry_t'(w_rdata);
    assign log_if.log_valid = ~w_empty;
    assign log_if.log_addr  = w_head.addr;
    assign log_if.log_data  = w_head.data;
    assign log_if.log_stamp = w_head.stamp;

    assign overflow = r_overflow;
    assign drops    = r_drops;

    // Phi2 history for rising-edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk2_q <= 1'b0;
        end else begin
            r_clk2_q <= clk2;
        end
    end

    // Free-running timestamp, untouched by clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stamp <= '0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
        end
    end

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drops != 8'hFF) begin
                r_drops <= r_drops + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_write_logger.sv
// tb/tb_bus_write_logger.sv - scoreboard bench for bus_write_logger
module tb_bus_write_logger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk2 = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  odata = 8'h00;
    logic        rw = 1'b1;
    logic        clear = 1'b0;
    logic [2:0]  count;
    logic        overflow;
    logic [7:0]  drops;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] exp_q [$];
    logic [15:0] tb_stamp;

    bus_write_logger_if lif ();

    bus_write_logger #(
        .DEPTH   (4),
        .ADDR_LO (16'h0100),
        .ADDR_HI (16'h01FF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk2     (clk2),
        .addr     (addr),
        .odata    (odata),
        .rw       (rw),
        .clear    (clear),
        .log_if   (lif.master),
        .count    (count),
        .overflow (overflow),
        .drops    (drops)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts clk edges since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_stamp <= 16'h0000;
        else          tb_stamp <= tb_stamp + 16'h0001;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry is compared against the scoreboard front
    always @(negedge clk) begin
        if (reset_n && lif.log_valid && lif.log_ready) begin
            logic [39:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_entry: got addr %0h data %0h stamp %0h, expected none",
                         lif.log_addr, lif.log_data, lif.log_stamp);
            end else begin
                e = exp_q.pop_front();
                if ({lif.log_stamp, lif.log_addr, lif.log_data} !== e) begin
                    n_fail++;
                    $display("FAIL entry: got stamp %0h addr %0h data %0h, expected stamp %0h addr %0h data %0h",
                             lif.log_stamp, lif.log_addr, lif.log_data, e[39:24], e[23:8], e[7:0]);
                end
            end
        end
    end

    // One phi2 period with a bus cycle; exp_log pushes the expected entry
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic r, input bit exp_log);
        @(posedge clk); #1;
        clk2 = 1'b1; rw = r; addr = a; odata = d;
        if (exp_log) exp_q.push_back({tb_stamp, a, d});
        @(posedge clk); #1;
        clk2 = 1'b0; rw = 1'b1;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        lif.log_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (count == 0 && exp_q.size() == 0) done = 1'b1;
        end
        chk({name, "_drained"}, int'(done), 1);
        lif.log_ready = 1'b0;
    endtask

    initial begin
        lif.log_ready = 1'b0;
        #2;
        chk("rst_valid", int'(lif.log_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_drops", int'(drops), 0);
        chk("rst_stamp", int'(lif.log_stamp), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Window filtering and boundaries
        bus_cycle(16'h0099, 8'h01, 1'b0, 1'b0);
        @(negedge clk); chk("out_of_window_count", int'(count), 0);
        bus_cycle(16'h0180, 8'h01, 1'b0, 1'b1);
        @(negedge clk); chk("in_window_count", int'(count), 1);
        chk("in_window_valid", int'(lif.log_valid), 1);
        chk("in_window_addr", int'(lif.log_addr), 16'h0180);
        bus_cycle(16'h00FF, 8'h11, 1'b0, 1'b0);
        bus_cycle(16'h0100, 8'h22, 1'b0, 1'b1);
        bus_cycle(16'h01FF, 8'h33, 1'b0, 1'b1);
        bus_cycle(16'h0200, 8'h44, 1'b0, 1'b0);
        bus_cycle(16'h0150, 8'h55, 1'b1, 1'b0);
        @(negedge clk); chk("boundary_count", int'(count), 3);
        drain("window");
        chk("empty_addr", int'(lif.log_addr), 0);
        chk("empty_data", int'(lif.log_data), 0);
        chk("empty_stamp", int'(lif.log_stamp), 0);

        // Six stores into a four-deep FIFO with no consumer
        for (int i = 0; i < 6; i++)
            bus_cycle(16'h0101 + 16'(i), 8'hA0 + 8'(i), 1'b0, i < 4);
        @(negedge clk);
        chk("ovf_count", int'(count), 4);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_drops", int'(drops), 2);
        drain("overflow");

        // Full FIFO, capture coincides with a pop
        for (int i = 0; i < 4; i++)
            bus_cycle(16'h0110 + 16'(i), 8'hB0 + 8'(i), 1'b0, 1'b1);
        @(negedge clk); chk("full_count", int'(count), 4);
        @(posedge clk); #1;
        lif.log_ready = 1'b1; clk2 = 1'b1; rw = 1'b0; addr = 16'h01A0; odata = 8'hEE;
        exp_q.push_back({tb_stamp, 16'h01A0, 8'hEE});
        @(posedge clk); #1;
        lif.log_ready = 1'b0; clk2 = 1'b0; rw = 1'b1;
        @(negedge clk);
        chk("pushpop_count", int'(count), 4);
        chk("pushpop_drops", int'(drops), 2);
        drain("pushpop");

        // Clear coinciding with a capture at count 3
        for (int i = 0; i < 3; i++)
            bus_cycle(16'h0120 + 16'(i), 8'hC0 + 8'(i), 1'b0, 1'b1);
        @(negedge clk); chk("pre_clear_count", int'(count), 3);
        @(posedge clk); #1;
        clear = 1'b1; clk2 = 1'b1; rw = 1'b0; addr = 16'h01C0; odata = 8'hCC;
        exp_q.delete();
        @(posedge clk); #1;
        clear = 1'b0; clk2 = 1'b0; rw = 1'b1;
        @(negedge clk);
        chk("clear_count", int'(count), 0);
        chk("clear_valid", int'(lif.log_valid), 0);
        chk("clear_overflow", int'(overflow), 0);
        chk("clear_drops", int'(drops), 0);
        bus_cycle(16'h01D0, 8'hD0, 1'b0, 1'b1);
        drain("post_clear");

        // Asynchronous reset with two entries queued
        bus_cycle(16'h0130, 8'h30, 1'b0, 1'b1);
        bus_cycle(16'h0131, 8'h31, 1'b0, 1'b1);
        @(negedge clk); chk("pre_reset_count", int'(count), 2);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", int'(lif.log_valid), 0);
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_stamp", int'(lif.log_stamp), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        clk2 = 1'b1; rw = 1'b0; addr = 16'h0155; odata = 8'h5A;
        exp_q.push_back({16'h0001, 16'h0155, 8'h5A});
        @(posedge clk); #1;
        clk2 = 1'b0; rw = 1'b1;
        @(negedge clk);
        chk("post_reset_stamp", int'(lif.log_stamp), 1);
        drain("post_reset");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
